// File: rtl/core_trace_buffer_if.sv
// Bundle of control, sample, trigger and readout signals for core_trace_buffer.
// master drives stimulus and consumes readout; slave is the trace buffer.
interface core_trace_buffer_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              arm;
    logic              abort;
    logic              sample_en;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] data_in;
    logic              trig_en;
    logic [DATA_W-1:0] trig_pc;
    logic              trig_force;
    logic              armed;
    logic              triggered;
    logic              done;
    logic [CW-1:0]     count;
    logic              rd_start;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    modport master (
        output arm, abort, sample_en, pc_in, data_in, trig_en, trig_pc, trig_force,
        output rd_start, rd_ready,
        input  armed, triggered, done, count, rd_valid, rd_pc, rd_data, rd_last
    );

    modport slave (
        input  arm, abort, sample_en, pc_in, data_in, trig_en, trig_pc, trig_force,
        input  rd_start, rd_ready,
        output armed, triggered, done, count, rd_valid, rd_pc, rd_data, rd_last
    );
endinterface

// File: rtl/core_trace_buffer.sv
// Triggerable circular trace of {pc, data} retire samples, read back oldest-first.
// state | meaning
// IDLE  | no capture; waits for arm
// ARMED | capturing pre-trigger history, watching for a hit
// POST  | trigger seen; capturing post_cnt more samples
// DONE  | buffer frozen; waits for rd_start
// READ  | streaming the window out over rd_valid/rd_ready
module core_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 16
) (
    input  logic                clk,
    input  logic                rst,
    core_trace_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_POST, S_DONE, S_READ} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem_pc   [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_post_cnt;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_rd_rem;
    logic              r_armed;
    logic              r_triggered;
    logic              r_done;
    logic              r_rd_valid;

    wire w_capturing = (r_state == S_ARMED) || (r_state == S_POST);
    wire w_wr_en     = w_capturing && bus.sample_en && !bus.abort;
    wire w_hit       = bus.sample_en &&
                       (bus.trig_force || (bus.trig_en && (bus.pc_in == bus.trig_pc)));
    wire [CW-1:0] w_count_inc = (r_count == CW'(DEPTH)) ? r_count : r_count + CW'(1);

    // Buffer contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_pc[r_wr_ptr]   <= bus.pc_in;
            r_mem_data[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_post_cnt  <= '0;
            r_count     <= '0;
            r_rd_rem    <= '0;
            r_armed     <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else if (bus.abort) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_armed     <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.arm) begin
                        r_state  <= S_ARMED;
                        r_wr_ptr <= '0;
                        r_count  <= '0;
                        r_armed  <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (bus.sample_en) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        r_count  <= w_count_inc;
                        if (w_hit) begin
                            r_armed <= 1'b0;
                            if (POST_TRIG == 0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state     <= S_POST;
                                r_post_cnt  <= AW'(POST_TRIG);
                                r_triggered <= 1'b1;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (bus.sample_en) begin
                        r_wr_ptr   <= r_wr_ptr + AW'(1);
                        r_count    <= w_count_inc;
                        r_post_cnt <= r_post_cnt - AW'(1);
                        if (r_post_cnt == AW'(1)) begin
                            r_state     <= S_DONE;
                            r_triggered <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.rd_start) begin
                        // A full buffer has wrapped, so the oldest entry sits at wr_ptr.
                        r_state    <= S_READ;
                        r_rd_ptr   <= (r_count == CW'(DEPTH)) ? r_wr_ptr : '0;
                        r_rd_rem   <= r_count;
                        r_rd_valid <= 1'b1;
                    end
                end
                S_READ: begin
                    if (bus.rd_ready) begin
                        r_rd_ptr <= r_rd_ptr + AW'(1);
                        r_rd_rem <= r_rd_rem - CW'(1);
                        if (r_rd_rem == CW'(1)) begin
                            r_state    <= S_IDLE;
                            r_rd_valid <= 1'b0;
                            r_done     <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.armed     = r_armed;
    assign bus.triggered = r_triggered;
    assign bus.done      = r_done;
    assign bus.count     = r_count;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_pc     = r_rd_valid ? r_mem_pc[r_rd_ptr]   : '0;
    assign bus.rd_data   = r_rd_valid ? r_mem_data[r_rd_ptr] : '0;
    assign bus.rd_last   = r_rd_valid && (r_rd_rem == CW'(1));

endmodule

// File: tb/tb_core_trace_buffer.sv
// Scoreboard bench: three trace buffers (POST_TRIG 2, 1, 0) share stimulus, arm is steered by sel.
// Readout transfers are popped and compared against hand-built expected windows.
module tb_core_trace_buffer;
    localparam int DW  = 32;
    localparam int DEP = 8;

    typedef struct {
        logic [DW-1:0] pc;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          arm, abort, sample_en, trig_en, trig_force, rd_start, rd_ready;
    logic [DW-1:0] pc_in, data_in, trig_pc;
    int            sel;
    int            n_checks = 0;
    int            n_fail   = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    function automatic logic [DW-1:0] dat(input logic [DW-1:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pop_check(input int k, input logic [DW-1:0] pc, input logic [DW-1:0] d,
                             input logic last);
        exp_t e;
        int   got = 0;
        case (k)
            0: if (q0.size() != 0) begin e = q0.pop_front(); got = 1; end
            1: if (q1.size() != 0) begin e = q1.pop_front(); got = 1; end
            default: if (q2.size() != 0) begin e = q2.pop_front(); got = 1; end
        endcase
        if (got == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_unexpected dut%0d: got pc %0h expected no transfer", k, pc);
        end else begin
            chk($sformatf("rd_pc dut%0d", k), 64'(pc), 64'(e.pc));
            chk($sformatf("rd_data dut%0d", k), 64'(d), 64'(e.data));
            chk($sformatf("rd_last dut%0d", k), 64'(last), 64'(e.last));
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        core_trace_buffer_if #(.DATA_W(DW), .DEPTH(DEP)) bus ();
        assign bus.arm        = arm && (sel == g);
        assign bus.abort      = abort;
        assign bus.sample_en  = sample_en;
        assign bus.pc_in      = pc_in;
        assign bus.data_in    = data_in;
        assign bus.trig_en    = trig_en;
        assign bus.trig_pc    = trig_pc;
        assign bus.trig_force = trig_force;
        assign bus.rd_start   = rd_start;
        assign bus.rd_ready   = rd_ready;

        core_trace_buffer #(.DATA_W(DW), .DEPTH(DEP), .POST_TRIG(2 - g)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        logic          stall_q = 1'b0;
        logic [DW-1:0] hold_q  = '0;
        always @(negedge clk) begin
            if (bus.rd_valid && bus.rd_ready)
                pop_check(g, bus.rd_pc, bus.rd_data, bus.rd_last);
            if (stall_q && bus.rd_valid)
                chk($sformatf("stall_pc_stable dut%0d", g), 64'(bus.rd_pc), 64'(hold_q));
            stall_q <= bus.rd_valid && !bus.rd_ready;
            hold_q  <= bus.rd_pc;
        end
    end

    function automatic logic [4:0] st(input int k);
        case (k)
            0: return {g_dut[0].bus.armed, g_dut[0].bus.triggered, g_dut[0].bus.done,
                       g_dut[0].bus.rd_valid, g_dut[0].bus.rd_last};
            1: return {g_dut[1].bus.armed, g_dut[1].bus.triggered, g_dut[1].bus.done,
                       g_dut[1].bus.rd_valid, g_dut[1].bus.rd_last};
            default: return {g_dut[2].bus.armed, g_dut[2].bus.triggered, g_dut[2].bus.done,
                             g_dut[2].bus.rd_valid, g_dut[2].bus.rd_last};
        endcase
    endfunction

    function automatic int cnt(input int k);
        case (k)
            0: return int'(g_dut[0].bus.count);
            1: return int'(g_dut[1].bus.count);
            default: return int'(g_dut[2].bus.count);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push(input int k, input logic [DW-1:0] pc, input logic last);
        exp_t e;
        e.pc = pc; e.data = dat(pc); e.last = last;
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [DW-1:0] pc, input logic force_t);
        sample_en = 1'b1; pc_in = pc; data_in = dat(pc); trig_force = force_t;
        tick();
        sample_en = 1'b0; trig_force = 1'b0;
    endtask

    task automatic do_arm(input int k);
        sel = k; arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Bits of st(): {armed, triggered, done, rd_valid, rd_last}
    task automatic drain(input int k, input logic toggle);
        int n = 0;
        rd_start = 1'b1; rd_ready = 1'b0;
        tick();
        rd_start = 1'b0;
        chk($sformatf("rd_valid_rise dut%0d", k), 64'(st(k)[1]), 64'(1));
        while ((qsize(k) != 0 || st(k)[1]) && n < 64) begin
            rd_ready = toggle ? ~rd_ready : 1'b1;
            tick();
            n++;
        end
        rd_ready = 1'b0;
        chk($sformatf("drain_in_time dut%0d", k), 64'(n < 64), 64'(1));
        chk($sformatf("post_read_status dut%0d", k), 64'(st(k)), 64'(0));
        chk($sformatf("post_read_queue dut%0d", k), 64'(qsize(k)), 64'(0));
    endtask

    initial begin
        rst = 1'b1; arm = 0; abort = 0; sample_en = 0; trig_en = 0; trig_force = 0;
        rd_start = 0; rd_ready = 0; pc_in = '0; data_in = '0; trig_pc = '0; sel = 0;
        #12;
        chk("reset_status", 64'(st(0)), 64'(0));
        chk("reset_count", 64'(cnt(0)), 64'(0));
        chk("reset_rd_pc", 64'(g_dut[0].bus.rd_pc), 64'(0));
        chk("reset_rd_data", 64'(g_dut[0].bus.rd_data), 64'(0));
        rst = 1'b0;
        tick();

        // Wrapping capture: window is 0x0C..0x28
        trig_en = 1'b1; trig_pc = 32'h20;
        do_arm(0);
        chk("t1_armed", 64'(st(0)), 64'b10000);
        for (int i = 0; i <= 16; i++) begin
            sample(32'(4 * i), 1'b0);
            if (i == 8)  chk("t1_triggered", 64'(st(0)), 64'b01000);
            if (i == 9)  chk("t1_not_done_0x24", 64'(st(0)[2]), 64'(0));
            if (i == 10) chk("t1_done_0x28", 64'(st(0)), 64'b00100);
            if (i == 10) chk("t1_count", 64'(cnt(0)), 64'(8));
        end
        chk("t1_count_frozen", 64'(cnt(0)), 64'(8));
        for (int i = 3; i <= 10; i++) push(0, 32'(4 * i), i == 10);
        drain(0, 1'b0);

        // Partial fill, POST_TRIG=1; sample coinciding with arm is dropped
        trig_pc = 32'h208;
        sel = 1; arm = 1'b1; sample_en = 1'b1; pc_in = 32'h1F0; data_in = dat(32'h1F0);
        tick();
        arm = 1'b0; sample_en = 1'b0;
        chk("t2_count_after_arm", 64'(cnt(1)), 64'(0));
        for (int i = 0; i < 4; i++) sample(32'h200 + 32'(4 * i), 1'b0);
        chk("t2_done", 64'(st(1)), 64'b00100);
        chk("t2_count", 64'(cnt(1)), 64'(4));
        for (int i = 0; i < 4; i++) push(1, 32'h200 + 32'(4 * i), i == 3);
        drain(1, 1'b0);

        // POST_TRIG=0, forced trigger on sample 5
        trig_en = 1'b0;
        do_arm(2);
        for (int i = 0; i < 4; i++) sample(32'h300 + 32'(4 * i), 1'b0);
        chk("t3_not_done", 64'(st(2)[2]), 64'(0));
        sample(32'h310, 1'b1);
        chk("t3_done", 64'(st(2)), 64'b00100);
        chk("t3_count", 64'(cnt(2)), 64'(5));
        sample(32'h314, 1'b0);
        chk("t3_frozen", 64'(cnt(2)), 64'(5));
        for (int i = 0; i < 5; i++) push(2, 32'h300 + 32'(4 * i), i == 4);
        drain(2, 1'b0);

        // Backpressure readout
        trig_en = 1'b1; trig_pc = 32'h108;
        do_arm(0);
        for (int i = 0; i < 5; i++) sample(32'h100 + 32'(4 * i), 1'b0);
        chk("t4_count", 64'(cnt(0)), 64'(5));
        for (int i = 0; i < 5; i++) push(0, 32'h100 + 32'(4 * i), i == 4);
        drain(0, 1'b1);

        // Abort during POST
        trig_pc = 32'h600;
        do_arm(0);
        sample(32'h600, 1'b0);
        chk("t5_post", 64'(st(0)), 64'b01000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_post_status", 64'(st(0)), 64'(0));
        chk("t5_abort_post_count", 64'(cnt(0)), 64'(0));
        sample(32'h604, 1'b1);
        chk("t5_idle_ignores_sample", 64'(cnt(0)), 64'(0));

        // Abort mid-readout
        trig_pc = 32'h404;
        do_arm(0);
        for (int i = 0; i < 4; i++) sample(32'h400 + 32'(4 * i), 1'b0);
        chk("t5_read_count", 64'(cnt(0)), 64'(4));
        push(0, 32'h400, 1'b0);
        push(0, 32'h404, 1'b0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0; rd_ready = 1'b1;
        tick();
        tick();
        rd_ready = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_read_status", 64'(st(0)), 64'(0));
        chk("t5_abort_read_count", 64'(cnt(0)), 64'(0));
        chk("t5_abort_read_queue", 64'(qsize(0)), 64'(0));

        // Fresh capture after abort
        trig_en = 1'b0;
        do_arm(0);
        sample(32'h500, 1'b1);
        sample(32'h504, 1'b0);
        sample(32'h508, 1'b0);
        chk("t5_fresh_count", 64'(cnt(0)), 64'(3));
        for (int i = 0; i < 3; i++) push(0, 32'h500 + 32'(4 * i), i == 2);
        drain(0, 1'b0);

        // Asynchronous reset while ARMED
        do_arm(0);
        sample(32'h700, 1'b0);
        sample(32'h704, 1'b0);
        chk("t6_armed", 64'(st(0)), 64'b10000);
        chk("t6_count", 64'(cnt(0)), 64'(2));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_status", 64'(st(0)), 64'(0));
        chk("t6_async_count", 64'(cnt(0)), 64'(0));
        #2;
        rst = 1'b0;
        tick();
        sample(32'h708, 1'b1);
        chk("t6_no_capture_status", 64'(st(0)), 64'(0));
        chk("t6_no_capture_count", 64'(cnt(0)), 64'(0));
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("t6_rd_start_ignored", 64'(st(0)[1]), 64'(0));
        chk("t6_queue_empty", 64'(qsize(0) + qsize(1) + qsize(2)), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/core_trace_buffer.md
# core_trace_buffer

Parametrised on-chip trace capture unit for the RISC-V core. It records per-cycle retire samples (PC plus one data word, normally the ALU result or register write-back value) into a circular buffer. It stops a programmable number of samples after a PC-match or forced trigger, then streams the captured window out oldest-first over a valid/ready port. It replaces manual waveform inspection of PC and ALU activity with a triggerable, bench-readable and hardware-readable history.

## Interface
Parameters:
- DATA_W, 32, width of PC and data words.
- DEPTH, 64, buffer entries; power of two, at least 4.
- POST_TRIG, 16, samples captured after the trigger sample; range 0 to DEPTH-1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  one-cycle pulse; starts a capture from IDLE.
- abort  in  1  synchronous return to IDLE from any state; discards the capture.
- sample_en  in  1  a sample is presented this cycle.
- pc_in  in  DATA_W  PC of the sample.
- data_in  in  DATA_W  data word of the sample.
- trig_en  in  1  enables PC-match triggering.
- trig_pc  in  DATA_W  trigger PC.
- trig_force  in  1  unconditional trigger when it coincides with a sample.
- armed  out  1  state is ARMED.
- triggered  out  1  state is POST.
- done  out  1  state is DONE or READ.
- count  out  $clog2(DEPTH)+1  valid entries held, saturating at DEPTH.
- rd_start  in  1  pulse in DONE; begins readout.
- rd_valid  out  1  rd_pc/rd_data hold a valid entry.
- rd_ready  in  1  consumer accepts the entry.
- rd_pc  out  DATA_W  PC of the current read entry; 0 when rd_valid=0.
- rd_data  out  DATA_W  data of the current read entry; 0 when rd_valid=0.
- rd_last  out  1  the current entry is the final one; only high with rd_valid.

## Operation
- States: IDLE, ARMED, POST, DONE, READ.
- Reset: state IDLE, wr_ptr=0, count=0. All outputs are 0. Buffer contents are not reset.
- IDLE: nothing is written. arm moves to ARMED with wr_ptr=0 and count=0. rd_start is ignored.
- ARMED: each sample_en writes {pc_in, data_in} to mem[wr_ptr].
  - wr_ptr increments mod DEPTH; count increments, saturating at DEPTH.
  - hit = sample_en & (trig_force | (trig_en & pc_in==trig_pc)).
  - On hit, the hit sample is written. If POST_TRIG=0, go to DONE; otherwise go to POST with post_cnt=POST_TRIG.
- POST: each sample_en writes as in ARMED and decrements post_cnt. The write that takes post_cnt to 0 moves to DONE. Further hits are ignored.
- DONE: the buffer is frozen and sample_en is ignored. rd_start moves to READ with rd_ptr = (count<DEPTH) ? 0 : wr_ptr and rd_rem=count.
- READ: rd_valid=1, rd_pc/rd_data = mem[rd_ptr], rd_last = (rd_rem==1).
  - A transfer occurs on rd_valid & rd_ready; it advances rd_ptr mod DEPTH and decrements rd_rem.
  - The transfer with rd_last moves to IDLE.
  - rd_pc/rd_data stay stable while rd_valid & !rd_ready.
- arm outside IDLE, and rd_start outside DONE, are ignored.
- abort has priority over every other input in every state. It goes to IDLE and clears count.
- On wrap, the oldest entry is overwritten. After the trigger, the window holds the trigger sample, up to DEPTH-1-POST_TRIG earlier samples, and POST_TRIG later samples.

## Timing
- Trigger compare is combinational on the current sample. The state change and the write both occur on the same clock edge.
- armed, triggered, done and count are registered. They reflect an event one edge after it is presented.
- arm to first possible capture: the sample presented in the cycle after the arm edge.
- Readout: rd_valid rises the edge after rd_start. Throughput is one entry per clock with rd_ready held high. Read data is combinational from the register array, with zero added latency.
- A window of N entries takes N cycles to drain; rd_valid falls on the edge of the rd_last transfer.
- A sample_en in the same cycle as arm is not captured.

## Test plan
- Basic trigger, DEPTH=8, POST_TRIG=2: arm, then PCs 0x00,0x04,…,0x40 with trig_pc=0x20. Required: done after 0x28 is written, count=8; readout yields 0x0C…0x28 oldest-first, with rd_last on 0x28.
- Partial fill, DEPTH=8, POST_TRIG=1: trigger on the 3rd sample. Required: count=4; readout of 4 entries starting at the first sample.
- POST_TRIG=0 with trig_force on sample 5: done the next edge; the last read entry is sample 5.
- Backpressure: toggle rd_ready every other cycle during readout. Required: no entry lost or duplicated, and rd_pc is stable while stalled.
- Abort: abort during POST, then during READ (mid-stream). Required: IDLE next edge, rd_valid=0, count=0. A fresh arm then captures normally.
- Reset mid-ARMED: assert rst asynchronously. Required: all outputs 0 immediately; arm is required again before any capture.
